uart_tx_dev: RTL

//  Bus-slave UART transmitter; a sibling device to the console on the SoC data bus (DEV slot, 4 KB window).

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_dev.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the bus-slave UART transmitter: register offsets,
// serializer states and STATUS bit positions.
package uart_pkg;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;
  localparam logic [1:0] UART_CTRL   = 2'd3;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_LEVEL_LSB = 8;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmit path. A push while full is
// accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Bus-slave UART transmitter: register file, bus decode and an 8N1 serializer
// draining the TX FIFO onto tx_o, LSB first.
module uart_tx_dev
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  tx_o,
  output logic                  irq_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]            reg_sel;
  logic                  wr_en, rd_en, push;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, status_w;
  logic [DIV_W-1:0]      div_q;
  logic                  tx_en_q, irq_en_q, ovf_q;

  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [7:0]            fifo_rdata;
  logic [LW-1:0]         fifo_level;

  tx_state_e             state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d, frame_div_q, frame_div_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  busy, start_ok, bit_end;

  logic                  unused_bits;
  assign unused_bits = ^{addr_i[ADDR_WIDTH-1:4], addr_i[1:0], wdata_i[DATA_WIDTH-1:16]};

  assign reg_sel = addr_i[3:2];
  assign wr_en   = req_i & we_i;
  assign rd_en   = req_i & ~we_i;
  assign push    = wr_en & (reg_sel == UART_TXDATA);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .wdata_i (wdata_i[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign busy  = (state_q != IDLE);
  assign irq_o = irq_en_q & fifo_empty & ~busy;

  always_comb begin
    status_w                          = '0;
    status_w[ST_BUSY]                 = busy;
    status_w[ST_FULL]                 = fifo_full;
    status_w[ST_EMPTY]                = fifo_empty;
    status_w[ST_OVF]                  = ovf_q;
    status_w[ST_LEVEL_LSB +: 8]       = 8'(fifo_level);
  end

  always_comb begin
    rdata_d = '0;
    case (reg_sel)
      UART_STATUS: rdata_d = status_w;
      UART_DIV:    rdata_d[DIV_W-1:0] = div_q;
      UART_CTRL:   rdata_d[1:0] = {irq_en_q, tx_en_q};
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      div_q    <= DIV_W'(DEFAULT_DIV);
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          UART_DIV: div_q <= (wdata_i[DIV_W-1:0] == '0) ? DIV_W'(1) : wdata_i[DIV_W-1:0];
          UART_CTRL: begin
            tx_en_q  <= wdata_i[0];
            irq_en_q <= wdata_i[1];
            if (wdata_i[2]) ovf_q <= 1'b0;
          end
          default: ;
        endcase
      end
      // A full FIFO still takes the byte when the serializer pops in the same cycle.
      if (push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      if (rd_en) rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_div_q <= DIV_W'(DEFAULT_DIV);
      bit_idx_q   <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_div_q <= frame_div_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
    end
  end

  assign start_ok = tx_en_q & ~fifo_empty;
  assign bit_end  = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_div_d = frame_div_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          fifo_pop    = 1'b1;
          shift_d     = fifo_rdata;
          frame_div_d = div_q;
          cnt_d       = div_q - 1'b1;
          state_d     = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d     = frame_div_q - 1'b1;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d     = frame_div_q - 1'b1;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Back-to-back frames: the next byte is popped with no idle gap.
          if (start_ok) begin
            fifo_pop    = 1'b1;
            shift_d     = fifo_rdata;
            frame_div_d = div_q;
            cnt_d       = div_q - 1'b1;
            state_d     = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_o = 1'b1;
    case (state_q)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift_q[0];
      default: tx_o = 1'b1;
    endcase
  end

endmodule
